// File: rtl/view_sequencer.sv
// view_sequencer: picks the 4-bit view index for the output mux, switching views only on
// v_sync rising edges. Views come from the switches, a debounced "next" button, or auto-cycling.
`default_nettype none

module view_sequencer #(
  parameter logic [15:0] VALID_MASK      = 16'h01FF,
  parameter int          DWELL_FRAMES    = 60,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        v_sync_in,
  input  logic [3:0]  sw_select,
  input  logic        btn_next,
  input  logic        auto_en,
  output logic [3:0]  select,
  output logic        select_changed,
  output logic        auto_active,
  output logic [15:0] frame_cnt
);

  localparam int              DB_W       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     DWELL_LAST = 16'(DWELL_FRAMES - 1);

  typedef enum logic [0:0] {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  state_t          state, state_n;
  logic [3:0]      pending, pending_n, select_n, sw_prev;
  logic [15:0]     dwell, dwell_n;
  logic            changed_n;
  logic            v_q, v_qq, frame_start, sw_change;
  logic            b_q, b_qq, btn_stable, next_press;
  logic [DB_W-1:0] db_cnt;

  // The search wraps all the way round, so a lone valid bit maps to itself.
  function automatic logic [3:0] next_valid(input logic [3:0] x);
    logic [3:0] r;
    logic [3:0] idx;
    logic       found;
    r     = 4'd0;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = x + 4'(i);
      if (!found && VALID_MASK[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign frame_start = v_q & ~v_qq;
  assign sw_change   = (sw_select != sw_prev);
  assign auto_active = (state == AUTO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q        <= 1'b0;
      v_qq       <= 1'b0;
      b_q        <= 1'b0;
      b_qq       <= 1'b0;
      btn_stable <= 1'b0;
      db_cnt     <= '0;
      next_press <= 1'b0;
      sw_prev    <= 4'd0;
      frame_cnt  <= 16'd0;
    end else begin
      v_q        <= v_sync_in;
      v_qq       <= v_q;
      b_q        <= btn_next;
      b_qq       <= b_q;
      sw_prev    <= sw_select;
      next_press <= 1'b0;
      if (frame_start)
        frame_cnt <= frame_cnt + 16'd1;
      // Any bounce back to the stable level restarts the qualification window.
      if (b_qq != btn_stable) begin
        if (db_cnt == DB_LAST) begin
          btn_stable <= b_qq;
          db_cnt     <= '0;
          next_press <= b_qq;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= MANUAL;
      pending        <= 4'd0;
      select         <= 4'd0;
      dwell          <= 16'd0;
      select_changed <= 1'b0;
    end else begin
      state          <= state_n;
      pending        <= pending_n;
      select         <= select_n;
      dwell          <= dwell_n;
      select_changed <= changed_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    select_n  = select;
    dwell_n   = dwell;
    changed_n = 1'b0;
    case (state)
      MANUAL: begin
        if (sw_change) begin
          if (VALID_MASK[sw_select])
            pending_n = sw_select;
        end else if (next_press) begin
          pending_n = next_valid(pending);
        end
        if (frame_start && (pending != select)) begin
          select_n  = pending;
          changed_n = 1'b1;
        end
        if (auto_en) begin
          state_n = AUTO;
          dwell_n = 16'd0;
        end
      end
      AUTO: begin
        if (frame_start) begin
          if (dwell == DWELL_LAST) begin
            dwell_n = 16'd0;
            if (next_valid(select) != select) begin
              select_n  = next_valid(select);
              changed_n = 1'b1;
            end
          end else begin
            dwell_n = dwell + 16'd1;
          end
        end
        // Leaving auto holds whatever view is on screen after this edge.
        if (!auto_en) begin
          state_n   = MANUAL;
          pending_n = select_n;
        end
      end
      default: state_n = MANUAL;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_view_sequencer.sv
// Directed bench for view_sequencer: two instances (default mask with short dwell, and a single-view mask).
`default_nettype none

module tb_view_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_sync = 1'b0;
  logic [3:0]  sw_a = 4'd0, sw_b = 4'd0;
  logic        btn_a = 1'b0, btn_b = 1'b0;
  logic        auto_a = 1'b0, auto_b = 1'b0;
  logic [3:0]  sel_a, sel_b;
  logic        chg_a, chg_b, act_a, act_b;
  logic [15:0] fc_a, fc_b;

  int checks = 0;
  int errors = 0;
  int n_chg_a = 0, n_chg_b = 0, presses_a = 0;
  int base;
  int exp4[6] = '{7, 8, 8, 0, 0, 1};

  always #5 clk = ~clk;

  view_sequencer #(.VALID_MASK(16'h01FF), .DWELL_FRAMES(2), .DEBOUNCE_CYCLES(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .v_sync_in(v_sync), .sw_select(sw_a), .btn_next(btn_a),
    .auto_en(auto_a), .select(sel_a), .select_changed(chg_a), .auto_active(act_a), .frame_cnt(fc_a)
  );

  view_sequencer #(.VALID_MASK(16'h0010), .DWELL_FRAMES(2), .DEBOUNCE_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .v_sync_in(v_sync), .sw_select(sw_b), .btn_next(btn_b),
    .auto_en(auto_b), .select(sel_b), .select_changed(chg_b), .auto_active(act_b), .frame_cnt(fc_b)
  );

  always @(posedge clk) begin
    if (chg_a === 1'b1) n_chg_a++;
    if (chg_b === 1'b1) n_chg_b++;
    if (dut_a.next_press === 1'b1) presses_a++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    v_sync = 1'b1;
    tick(4);
    v_sync = 1'b0;
    tick(6);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_select", sel_a, 0);
    chk("rst_changed", chg_a, 0);
    chk("rst_auto", act_a, 0);
    chk("rst_fcnt", fc_a, 0);
    rst_n = 1'b1;

    // Switch to 5, exact latency of the first frame
    sw_a = 4'd5;
    sw_b = 4'd4;
    tick(5);
    chk("pre_frame_select", sel_a, 0);
    v_sync = 1'b1;
    tick(1);
    chk("lat_edge1_select", sel_a, 0);
    tick(1);
    chk("lat_edge2_select", sel_a, 5);
    chk("lat_edge2_changed", chg_a, 1);
    tick(1);
    chk("lat_pulse_end", chg_a, 0);
    tick(1);
    v_sync = 1'b0;
    tick(6);
    frame();
    frame();
    chk("fcnt_3", fc_a, 3);
    chk("one_change", n_chg_a, 1);
    chk("b_select_4", sel_b, 4);

    // Invalid switch index is ignored
    sw_a = 4'd12;
    frame();
    frame();
    chk("invalid_sw_select", sel_a, 5);
    chk("invalid_sw_nochg", n_chg_a, 1);
    sw_a = 4'd8;
    frame();
    chk("sw8_select", sel_a, 8);

    // Bouncing button, then a clean hold: one press, 8 wraps to 0
    for (int i = 0; i < 5; i++) begin
      btn_a = ~btn_a;
      tick(1);
    end
    btn_a = 1'b1;
    tick(40);
    chk("press_count", presses_a, 1);
    frame();
    chk("press_wrap_select", sel_a, 0);
    btn_a = 1'b0;
    tick(40);
    chk("release_no_press", presses_a, 1);

    // Auto cycling from 7 with a two-frame dwell
    sw_a = 4'd7;
    frame();
    chk("pre_auto_select", sel_a, 7);
    base = n_chg_a;
    auto_a = 1'b1;
    tick(3);
    chk("auto_active", act_a, 1);
    for (int i = 0; i < 6; i++) begin
      frame();
      chk($sformatf("auto_frame%0d", i), sel_a, exp4[i]);
    end
    chk("auto_changes", n_chg_a - base, 3);
    auto_a = 1'b0;
    tick(3);
    chk("manual_again", act_a, 0);
    frame();
    chk("hold_after_auto", sel_a, 1);
    chk("hold_no_change", n_chg_a - base, 3);

    // Single populated view: auto and press both stay put
    auto_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame();
      chk($sformatf("b_auto_frame%0d", i), sel_b, 4);
    end
    auto_b = 1'b0;
    tick(3);
    btn_b = 1'b1;
    tick(40);
    btn_b = 1'b0;
    frame();
    chk("b_press_select", sel_b, 4);
    chk("b_changes", n_chg_b, 1);

    // Asynchronous reset in the middle of a frame
    sw_a = 4'd6;
    frame();
    chk("pre_reset_select", sel_a, 6);
    auto_a = 1'b1;
    tick(3);
    v_sync = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_select", sel_a, 0);
    chk("async_rst_changed", chg_a, 0);
    chk("async_rst_auto", act_a, 0);
    chk("async_rst_fcnt", fc_a, 0);
    auto_a = 1'b0;
    v_sync = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    frame();
    chk("post_rst_fcnt", fc_a, 1);
    chk("post_rst_select", sel_a, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
